// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: request/ack handshake with byte enables.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU pass-through in one cycle, loads/stores through a
// req/ack data-memory port with alignment checking, extension and timeout abort.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [31:0] in_rd_wb,
  input  logic [31:0] in_branch_res,
  input  logic        in_wrenable,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [1:0]  in_size,
  input  logic        in_sign_ext,
  mem_access_stage_if.master mem,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] result,
  output logic [31:0] rd_wb,
  output logic [31:0] branch_result,
  output logic        wrenable,
  output logic        mem_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, WAIT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            sign_q, sign_d;
  logic            wren_lat_q, wren_lat_d;
  logic [31:0]     result_q, result_d;
  logic [31:0]     rd_q, rd_d;
  logic [31:0]     br_q, br_d;
  logic            wren_q, wren_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            is_mem;
  logic            aligned;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new;
  logic [31:0]     lane;
  logic [31:0]     load_val;
  logic            busy;

  assign is_mem = in_mem_read | in_mem_write;
  assign busy   = (state_q == WAIT);

  always_comb begin
    unique case (in_size)
      2'b00: begin
        aligned   = 1'b1;
        be_new    = 4'b0001 << in_alu_result[1:0];
        wdata_new = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        aligned   = ~in_alu_result[0];
        be_new    = 4'b0011 << in_alu_result[1:0];
        wdata_new = {2{in_store_data[15:0]}};
      end
      default: begin
        aligned   = (in_alu_result[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = in_store_data;
      end
    endcase
  end

  // Selected lane is shifted down to bit 0 before extension.
  always_comb begin
    lane = mem.mem_rdata >> {addr_q[1:0], 3'b000};
    unique case (size_q)
      2'b00:   load_val = {{24{sign_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{sign_q & lane[15]}}, lane[15:0]};
      default: load_val = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_d     = sign_q;
    wren_lat_d = wren_lat_q;
    result_d   = result_q;
    rd_d       = rd_q;
    br_d       = br_q;
    wren_d     = wren_q;
    valid_d    = valid_q;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!in_valid) begin
          valid_d = 1'b0;
          wren_d  = 1'b0;
        end else begin
          rd_d = in_rd_wb;
          br_d = in_branch_res;
          if (!is_mem) begin
            result_d = in_alu_result;
            wren_d   = in_wrenable;
            valid_d  = 1'b1;
          end else if (!aligned) begin
            result_d = in_alu_result;
            wren_d   = 1'b0;
            valid_d  = 1'b1;
            err_d    = 1'b1;
          end else begin
            // Read wins when both read and write are flagged.
            addr_d     = in_alu_result;
            wdata_d    = wdata_new;
            be_d       = be_new;
            we_d       = in_mem_write & ~in_mem_read;
            size_d     = in_size;
            sign_d     = in_sign_ext;
            wren_lat_d = in_wrenable;
            valid_d    = 1'b0;
            wren_d     = 1'b0;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          wren_d   = we_q ? 1'b0 : wren_lat_q;
          result_d = we_q ? addr_q : load_val;
        end else if (cnt_q == LAST) begin
          state_d  = IDLE;
          valid_d  = 1'b1;
          wren_d   = 1'b0;
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      wren_lat_q <= 1'b0;
      result_q   <= '0;
      rd_q       <= '0;
      br_q       <= '0;
      wren_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      wren_lat_q <= wren_lat_d;
      result_q   <= result_d;
      rd_q       <= rd_d;
      br_q       <= br_d;
      wren_q     <= wren_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy & we_q;
  assign mem.mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
  assign mem.mem_wdata = busy ? wdata_q : '0;
  assign mem.mem_be    = busy ? be_q : '0;

  assign stall         = busy;
  assign out_valid     = valid_q;
  assign result        = result_q;
  assign rd_wb         = rd_q;
  assign branch_result = br_q;
  assign wrenable      = wren_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level expectation queue.
module tb_mem_access_stage;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_store_data = '0;
  logic [31:0] in_rd_wb = '0;
  logic [31:0] in_branch_res = '0;
  logic        in_wrenable = 1'b0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic [1:0]  in_size = '0;
  logic        in_sign_ext = 1'b0;
  logic        stall, out_valid, wrenable, mem_err;
  logic [31:0] result, rd_wb, branch_result;

  mem_access_stage_if mif();

  mem_access_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_alu_result(in_alu_result),
    .in_store_data(in_store_data), .in_rd_wb(in_rd_wb), .in_branch_res(in_branch_res),
    .in_wrenable(in_wrenable), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_size(in_size), .in_sign_ext(in_sign_ext), .mem(mif), .stall(stall),
    .out_valid(out_valid), .result(result), .rd_wb(rd_wb), .branch_result(branch_result),
    .wrenable(wrenable), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic [31:0] res, rd, br;
    logic        wren, err;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] alu, sd, rd, br;
    logic        wren, rd_en, wr_en;
    logic [1:0]  size;
    logic        sign;
    int          ack_at;
    logic [31:0] rdata;
  } ins_t;

  exp_t expq[$];
  ins_t pend[$];
  ins_t cur;
  bit   in_mem = 0;
  int   wait_idx = 0;
  bit   cmp_en = 0;
  int unsigned passes = 0;
  int unsigned total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passes++;
  endtask

  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_aligned(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) == 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
    int unsigned mask;
    mask = (1 << nbytes(sz)) - 1;
    if (nbytes(sz) == 4) return 4'hF;
    return 4'(mask << (a % 4));
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    v = rdat >> (8 * (a % 4));
    if (sz == 2'b00) begin
      v = v & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rdat;
    end
    return v;
  endfunction

  function automatic ins_t mk(input logic [31:0] alu, input logic rd_en, input logic wr_en,
                              input logic [1:0] sz, input logic sg, input logic wren,
                              input logic [31:0] sd, input int ack_at, input logic [31:0] rdat);
    ins_t i;
    i.valid = 1'b1; i.alu = alu; i.sd = sd; i.rd = $urandom; i.br = $urandom;
    i.wren = wren; i.rd_en = rd_en; i.wr_en = wr_en; i.size = sz; i.sign = sg;
    i.ack_at = ack_at; i.rdata = rdat;
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    int unsigned k;
    k = $urandom_range(0, 9);
    i = mk($urandom, k inside {[4:6], 9}, k inside {[7:9]}, 2'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom), $urandom,
           ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(0, 4)), $urandom);
    if ($urandom_range(0, 1) == 1) i.alu[1:0] = 2'b00;
    i.valid = ($urandom_range(0, 6) != 0);
    return i;
  endfunction

  // One clock of bench activity: memory responder, then upstream driver.
  task automatic step();
    bit   busy;
    ins_t n;
    exp_t e;
    busy = in_mem;
    mif.mem_ack = 1'b0;
    if (busy) begin
      chk("stall_wait", stall, 1);
      chk("mem_req", mif.mem_req, 1);
      chk("mem_we", mif.mem_we, cur.wr_en & ~cur.rd_en);
      chk("mem_addr", mif.mem_addr, cur.alu & 32'hFFFF_FFFC);
      chk("mem_be", mif.mem_be, be_of(cur.size, cur.alu));
      if (cur.wr_en && !cur.rd_en) chk("mem_wdata", mif.mem_wdata, wd_of(cur.size, cur.sd));
      e.due = cyc + 1; e.rd = cur.rd; e.br = cur.br;
      if (cur.ack_at == wait_idx) begin
        mif.mem_ack = 1'b1;
        mif.mem_rdata = cur.rdata;
        e.err = 1'b0;
        if (cur.rd_en) begin
          e.res = model_load(cur.rdata, cur.alu, cur.size, cur.sign);
          e.wren = cur.wren;
        end else begin
          e.res = cur.alu;
          e.wren = 1'b0;
        end
        expq.push_back(e);
        in_mem = 0;
      end else if (wait_idx == int'(TO) - 1) begin
        e.res = '0; e.wren = 1'b0; e.err = 1'b1;
        expq.push_back(e);
        in_mem = 0;
      end
      wait_idx++;
    end else begin
      chk("stall_idle", stall, 0);
      chk("mem_req_idle", mif.mem_req, 0);
    end

    if (busy) begin
      n = rand_ins();
    end else if (pend.size() > 0) begin
      n = pend.pop_front();
    end else begin
      n = rand_ins();
      n.valid = 1'b0;
    end
    in_valid = n.valid; in_alu_result = n.alu; in_store_data = n.sd; in_rd_wb = n.rd;
    in_branch_res = n.br; in_wrenable = n.wren; in_mem_read = n.rd_en;
    in_mem_write = n.wr_en; in_size = n.size; in_sign_ext = n.sign;

    if (!busy && n.valid) begin
      e.due = cyc + 1; e.rd = n.rd; e.br = n.br; e.res = n.alu;
      if (!(n.rd_en || n.wr_en)) begin
        e.wren = n.wren; e.err = 1'b0;
        expq.push_back(e);
      end else if (!is_aligned(n.size, n.alu)) begin
        e.wren = 1'b0; e.err = 1'b1;
        expq.push_back(e);
      end else begin
        cur = n;
        in_mem = 1;
        wait_idx = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
          exp_t e;
          e = expq.pop_front();
          chk("out_valid", out_valid, 1);
          chk("result", result, e.res);
          chk("rd_wb", rd_wb, e.rd);
          chk("branch_result", branch_result, e.br);
          chk("wrenable", wrenable, e.wren);
          chk("mem_err", mem_err, e.err);
        end else begin
          chk("out_valid_none", out_valid, 0);
          chk("wrenable_none", wrenable, 0);
          chk("mem_err_none", mem_err, 0);
        end
      end
    end
  end

  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;

    chk("pin_lb", model_load(32'h80FF_FFFF, 32'h103, 2'b00, 1'b1), 32'hFFFF_FF80);
    chk("pin_lhu", model_load(32'hBEEF_1234, 32'h2, 2'b01, 1'b0), 32'h0000_BEEF);
    chk("pin_lh", model_load(32'hBEEF_1234, 32'h2, 2'b01, 1'b1), 32'hFFFF_BEEF);
    chk("pin_be_lb", be_of(2'b00, 32'h103), 4'b1000);
    chk("pin_be_sh", be_of(2'b01, 32'h102), 4'b1100);
    chk("pin_wd_sh", wd_of(2'b01, 32'h0000_ABCD), 32'hABCD_ABCD);
    chk("pin_wd_sb", wd_of(2'b00, 32'h1234_5678), 32'h7878_7878);
    chk("pin_align", is_aligned(2'b10, 32'h101), 0);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    cmp_en = 1;

    pend.push_back(mk(32'h1234, 0, 0, 2'b10, 0, 1, 0, 0, 0));
    pend.push_back(mk(32'h103, 1, 0, 2'b00, 1, 1, 0, 2, 32'h80FF_FFFF));
    pend.push_back(mk(32'h102, 0, 1, 2'b01, 0, 1, 32'h0000_ABCD, 0, 0));
    pend.push_back(mk(32'h101, 1, 0, 2'b10, 0, 1, 0, 0, 0));
    pend.push_back(mk(32'h200, 1, 0, 2'b10, 0, 1, 0, -1, 0));
    pend.push_back(mk(32'h204, 1, 1, 2'b10, 0, 1, 32'h5A5A_5A5A, 1, 32'hCAFE_F00D));
    pend.push_back(mk(32'h55, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 300; i++) pend.push_back(rand_ins());

    for (int k = 0; k < 20000 && (pend.size() > 0 || in_mem || expq.size() > 0); k++) step();
    chk("drained", 32'(pend.size() + expq.size()) + 32'(in_mem), 0);

    cmp_en = 0;
    in_valid = 1'b1; in_alu_result = 32'h40; in_mem_read = 1'b1; in_mem_write = 1'b0;
    in_size = 2'b10; in_wrenable = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstwait_stall", stall, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mif.mem_ack = 1'b1;
    mif.mem_rdata = 32'hFFFF_FFFF;
    chk("rstwait_req", mif.mem_req, 0);
    chk("rstwait_stall0", stall, 0);
    @(negedge clk);
    mif.mem_ack = 1'b0;
    chk("ackign_valid", out_valid, 0);
    chk("ackign_result", result, 0);
    chk("ackign_wren", wrenable, 0);
    chk("ackign_err", mem_err, 0);
    chk("ackign_rd", rd_wb, 0);
    chk("ackign_br", branch_result, 0);
    chk("ackign_stall", stall, 0);
    chk("ackign_req", mif.mem_req, 0);
    in_valid = 1'b1; in_mem_read = 1'b0; in_alu_result = 32'h5555_AAAA; in_wrenable = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_alu_valid", out_valid, 1);
    chk("post_alu_result", result, 32'h5555_AAAA);
    chk("post_alu_wren", wrenable, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
